// File: rtl/dat_xfer_ctrl_if.sv
// Interface between the host register side, the DAT `communication` stage and
// the buffer, as seen by dat_xfer_ctrl. The controller connects through the
// slave modport; the host/bench side drives through the master modport.
interface dat_xfer_ctrl_if #(
  parameter int BSZ_W  = 12,
  parameter int BCNT_W = 16,
  parameter int TO_W   = 16
);
  // Handshake rules: start is a one-cycle strobe and is accepted only while
  // xfer_busy is 0 (otherwise it is dropped). ack_o_buff / ack_o_card each mark
  // exactly one completed word per high cycle and are only meaningful while
  // trans_enable is 1. buf_re / buf_we / finished / size_err are one-cycle
  // strobes. abort may be raised at any time and overrides everything else.
  logic              start;
  logic              abort;
  logic              dir_i;
  logic              wide_i;
  logic              multi_i;
  logic [BSZ_W-1:0]  block_size;
  logic [BCNT_W-1:0] block_count;
  logic [TO_W-1:0]   timeout_val;
  logic              ack_o_buff;
  logic              ack_o_card;
  logic              card_busy_n;

  logic              trans_enable;
  logic              direction;
  logic              mode;
  logic              buf_re;
  logic              buf_we;
  logic [BCNT_W-1:0] blocks_done;
  logic              xfer_busy;
  logic              finished;
  logic              timeout_err;
  logic              size_err;

  modport master (
    output start, abort, dir_i, wide_i, multi_i, block_size, block_count,
           timeout_val, ack_o_buff, ack_o_card, card_busy_n,
    input  trans_enable, direction, mode, buf_re, buf_we, blocks_done,
           xfer_busy, finished, timeout_err, size_err
  );

  modport slave (
    input  start, abort, dir_i, wide_i, multi_i, block_size, block_count,
           timeout_val, ack_o_buff, ack_o_card, card_busy_n,
    output trans_enable, direction, mode, buf_re, buf_we, blocks_done,
           xfer_busy, finished, timeout_err, size_err
  );
endinterface

// File: rtl/dat_xfer_ctrl.sv
// dat_xfer_ctrl: block-transfer sequencer in front of the DAT `communication`
// stage. Latches a command, enables the serializer word by word, counts words
// and blocks, strobes the buffer, and handles card busy, timeout and abort.
// Optional feature macro: DAT_BUSY_WAIT_EN -- when defined, writes wait for the
// card to release DAT0 (card_busy_n=1) after every block before continuing.
// All outputs are registers; state is mirrored on state_dbg.
module dat_xfer_ctrl #(
  parameter int BSZ_W  = 12,
  parameter int BCNT_W = 16,
  parameter int TO_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  dat_xfer_ctrl_if.slave bus,
  output logic [2:0]     state_dbg
);
  localparam int WW = BSZ_W - 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_XFER      = 3'd2,
    S_GAP       = 3'd3,
    S_BUSY_WAIT = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  state_t            state;
  logic [WW-1:0]     words_init;
  logic [WW-1:0]     words_left;
  logic [BCNT_W-1:0] blocks_left;
  logic [BCNT_W-1:0] blk_cnt;
  logic              open_ended;
  logic              dir_r;
  logic [TO_W-1:0]   to_val;
  logic [TO_W-1:0]   to_cnt;
`ifdef DAT_BUSY_WAIT_EN
  // Remembers, while waiting on card busy, whether the block just sent was the last.
  logic              last_seen;
`endif

  logic              ack;
  logic              last_word;
  logic              last_block;
  logic [TO_W-1:0]   to_next;
  logic              to_hit;
  logic [WW-1:0]     size_words;

  // Byte count is rounded down to whole 32-bit words; the low two bits never matter.
  assign size_words = bus.block_size[BSZ_W-1:2];
`ifdef DAT_BUSY_WAIT_EN
  logic unused_bits;
  assign unused_bits = ^bus.block_size[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{bus.block_size[1:0], bus.card_busy_n};
`endif

  // Only the ack matching the latched direction counts as progress.
  assign ack        = dir_r ? bus.ack_o_buff : bus.ack_o_card;
  assign last_word  = (words_left == WW'(1));
  assign last_block = !open_ended && (blocks_left == BCNT_W'(1));
  assign to_next    = to_cnt + TO_W'(1);
  assign to_hit     = (to_val != '0) && (to_next == to_val);

  assign bus.blocks_done = blk_cnt;
  assign bus.direction   = dir_r;
  assign state_dbg       = state;

  // Main sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      words_init       <= '0;
      words_left       <= '0;
      blocks_left      <= '0;
      blk_cnt          <= '0;
      open_ended       <= 1'b0;
      dir_r            <= 1'b0;
      to_val           <= '0;
      to_cnt           <= '0;
`ifdef DAT_BUSY_WAIT_EN
      last_seen        <= 1'b0;
`endif
      bus.trans_enable <= 1'b0;
      bus.mode         <= 1'b0;
      bus.buf_re       <= 1'b0;
      bus.buf_we       <= 1'b0;
      bus.xfer_busy    <= 1'b0;
      bus.finished     <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.size_err     <= 1'b0;
    end else begin
      // Strobes are high for a single cycle unless re-asserted below.
      bus.buf_re   <= 1'b0;
      bus.buf_we   <= 1'b0;
      bus.finished <= 1'b0;
      bus.size_err <= 1'b0;

      if (bus.abort) begin
        // Abort overrides any ack or start seen in the same cycle.
        state            <= S_IDLE;
        bus.trans_enable <= 1'b0;
        bus.xfer_busy    <= 1'b0;
        bus.timeout_err  <= 1'b0;
        blk_cnt          <= '0;
        words_left       <= '0;
        blocks_left      <= '0;
        to_cnt           <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (size_words == '0) begin
                bus.size_err <= 1'b1;
              end else begin
                dir_r           <= bus.dir_i;
                bus.mode        <= bus.wide_i;
                words_init      <= size_words;
                words_left      <= size_words;
                blocks_left     <= bus.multi_i ? bus.block_count : BCNT_W'(1);
                open_ended      <= bus.multi_i && (bus.block_count == '0);
                to_val          <= bus.timeout_val;
                to_cnt          <= '0;
                blk_cnt         <= '0;
                bus.timeout_err <= 1'b0;
                bus.xfer_busy   <= 1'b1;
                // Writes prefetch the first word so it is ready for the serializer.
                bus.buf_re      <= !bus.dir_i;
                state           <= S_LOAD;
              end
            end
          end

          S_LOAD: begin
            bus.trans_enable <= 1'b1;
            to_cnt           <= '0;
            state            <= S_XFER;
          end

          S_XFER: begin
            if (ack) begin
              bus.trans_enable <= 1'b0;
              to_cnt           <= '0;
              bus.buf_we       <= dir_r;
              // Writes fetch the next word after every ack except the final one.
              bus.buf_re       <= !dir_r && !(last_word && last_block);
              if (!last_word) begin
                words_left <= words_left - WW'(1);
                state      <= S_GAP;
              end else begin
                words_left <= words_init;
                blk_cnt    <= blk_cnt + BCNT_W'(1);
                if (!last_block && !open_ended) begin
                  blocks_left <= blocks_left - BCNT_W'(1);
                end
`ifdef DAT_BUSY_WAIT_EN
                if (!dir_r) begin
                  last_seen <= last_block;
                  state     <= S_BUSY_WAIT;
                end else if (last_block) begin
                  bus.finished <= 1'b1;
                  state        <= S_DONE;
                end else begin
                  state <= S_GAP;
                end
`else
                if (last_block) begin
                  bus.finished <= 1'b1;
                  state        <= S_DONE;
                end else begin
                  state <= S_GAP;
                end
`endif
              end
            end else if (to_hit) begin
              bus.trans_enable <= 1'b0;
              bus.timeout_err  <= 1'b1;
              state            <= S_ERR;
            end else begin
              to_cnt <= to_next;
            end
          end

          S_GAP: begin
            // One idle cycle lets the serializer re-arm before the next word.
            bus.trans_enable <= 1'b1;
            to_cnt           <= '0;
            state            <= S_XFER;
          end

`ifdef DAT_BUSY_WAIT_EN
          S_BUSY_WAIT: begin
            if (bus.card_busy_n) begin
              to_cnt <= '0;
              if (last_seen) begin
                bus.finished <= 1'b1;
                state        <= S_DONE;
              end else begin
                state <= S_GAP;
              end
            end else if (to_hit) begin
              bus.timeout_err <= 1'b1;
              state           <= S_ERR;
            end else begin
              to_cnt <= to_next;
            end
          end
`endif

          S_DONE: begin
            bus.xfer_busy <= 1'b0;
            state         <= S_IDLE;
          end

          S_ERR: begin
            // timeout_err stays set; only start or abort clears it.
            bus.xfer_busy <= 1'b0;
            state         <= S_IDLE;
          end

          default: begin
            bus.trans_enable <= 1'b0;
            bus.xfer_busy    <= 1'b0;
            state            <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dat_xfer_ctrl.sv
// Testbench for dat_xfer_ctrl. The stimulus tasks describe each command as a
// sequence of words and blocks and, from the protocol timing rules, queue the
// expected output vector for every clock cycle; one compare process checks
// the DUT against that queue on every falling edge.
module tb_dat_xfer_ctrl;
  localparam int EW = 25;
`ifdef DAT_BUSY_WAIT_EN
  localparam bit BW = 1'b1;
`else
  localparam bit BW = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dat_xfer_ctrl_if bus ();

  dat_xfer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- model state / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic          m_dir;
  logic          m_mode;
  logic [15:0]   m_bd;
  logic          m_terr;
  int            chk_cnt;
  int            pass_cnt;
  int            cnt_re;
  int            cnt_we;
  int            cnt_fin;

  // Expected vector: {trans_enable, direction, mode, buf_re, buf_we,
  //                   blocks_done[15:0], xfer_busy, finished, timeout_err, size_err}
  function automatic logic [EW-1:0] mk(input logic te, input logic re, input logic we,
                                       input logic busy, input logic fin, input logic serr);
    return {te, m_dir, m_mode, re, we, m_bd, busy, fin, m_terr, serr};
  endfunction

  // Per-cycle compare against the queued expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.trans_enable, bus.direction, bus.mode, bus.buf_re, bus.buf_we,
           bus.blocks_done, bus.xfer_busy, bus.finished, bus.timeout_err, bus.size_err};
      chk_cnt = chk_cnt + 1;
      if (a === e) pass_cnt = pass_cnt + 1;
      else $display("FAIL cycle_vec t=%0t got te,dir,mode,re,we=%b bd=%0d busy,fin,terr,serr=%b ; want te,dir,mode,re,we=%b bd=%0d busy,fin,terr,serr=%b",
                    $time, a[24:20], a[19:4], a[3:0], e[24:20], e[19:4], e[3:0]);
    end
  end

  // Pulse counters used by the literal end-of-test checks.
  always @(negedge clk) begin
    if (bus.buf_re === 1'b1)   cnt_re  = cnt_re + 1;
    if (bus.buf_we === 1'b1)   cnt_we  = cnt_we + 1;
    if (bus.finished === 1'b1) cnt_fin = cnt_fin + 1;
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] want);
    chk_cnt = chk_cnt + 1;
    if (act === want) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s got %0d want %0d", name, act, want);
  endtask

  // ---------------- driver tasks ----------------
  // Advance into the next cycle and record what the outputs must be in it.
  task automatic cyc(input logic [EW-1:0] e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic quiet();
    bus.start      = 1'b0;
    bus.ack_o_buff = 1'b0;
    bus.ack_o_card = 1'b0;
  endtask

  // Random junk during a transfer: stray starts, new command fields and the
  // ack that does not belong to this direction must all be ignored.
  task automatic noise(input logic dir);
    bus.start       = ($urandom_range(0, 3) == 0);
    bus.dir_i       = 1'($urandom_range(0, 1));
    bus.wide_i      = 1'($urandom_range(0, 1));
    bus.multi_i     = 1'($urandom_range(0, 1));
    bus.block_size  = 12'($urandom);
    bus.block_count = 16'($urandom);
    bus.timeout_val = 16'($urandom_range(1, 3));
    if (dir) bus.ack_o_card = 1'($urandom_range(0, 1));
    else     bus.ack_o_buff = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_counts();
    cnt_re  = 0;
    cnt_we  = 0;
    cnt_fin = 0;
  endtask

  // One command. run_blocks bounds open-ended runs; abort_ack (1-based word
  // index, 0 = never) raises abort in that word's ack cycle; busy_len < 0
  // picks a random card-busy length.
  task automatic run_cmd(input logic dir, input logic wide, input logic multi,
                         input logic [11:0] bsize, input logic [15:0] bcnt,
                         input logic [15:0] tmo, input int run_blocks,
                         input int abort_ack, input int busy_len);
    int   words;
    int   nblk;
    int   ackn;
    int   d;
    int   nb;
    logic open;
    logic last_w;
    logic last_x;
    words           = int'(bsize[11:2]);
    bus.dir_i       = dir;
    bus.wide_i      = wide;
    bus.multi_i     = multi;
    bus.block_size  = bsize;
    bus.block_count = bcnt;
    bus.timeout_val = tmo;
    bus.start       = 1'b1;
    if (words == 0) begin
      cyc(mk(0, 0, 0, 0, 0, 1));
      quiet();
      cyc(mk(0, 0, 0, 0, 0, 0));
      return;
    end
    open   = multi && (bcnt == 16'd0);
    nblk   = open ? run_blocks : (multi ? int'(bcnt) : 1);
    m_dir  = dir;
    m_mode = wide;
    m_bd   = 16'd0;
    m_terr = 1'b0;
    cyc(mk(0, !dir, 0, 1, 0, 0));
    quiet();
    ackn = 0;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < words; w++) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i <= d; i++) begin
          cyc(mk(1, 0, 0, 1, 0, 0));
          noise(dir);
          if (i == d) begin
            if (dir) bus.ack_o_buff = 1'b1;
            else     bus.ack_o_card = 1'b1;
            ackn = ackn + 1;
            if (ackn == abort_ack) bus.abort = 1'b1;
          end
        end
        if (ackn == abort_ack) begin
          m_bd   = 16'd0;
          m_terr = 1'b0;
          cyc(mk(0, 0, 0, 0, 0, 0));
          bus.abort = 1'b0;
          quiet();
          return;
        end
        last_w = (w == words - 1);
        last_x = last_w && (b == nblk - 1) && !open;
        if (last_w) m_bd = m_bd + 16'd1;
        if (!dir && BW && last_w) begin
          nb = (busy_len < 0) ? $urandom_range(0, 4) : busy_len;
          for (int i = 0; i <= nb; i++) begin
            cyc(mk(0, (i == 0) && !last_x, 0, 1, 0, 0));
            quiet();
            bus.card_busy_n = (i == nb);
          end
          if (last_x) begin
            cyc(mk(0, 0, 0, 1, 1, 0));
            cyc(mk(0, 0, 0, 0, 0, 0));
          end else begin
            cyc(mk(0, 0, 0, 1, 0, 0));
          end
        end else if (last_x) begin
          cyc(mk(0, 0, dir, 1, 1, 0));
          quiet();
          cyc(mk(0, 0, 0, 0, 0, 0));
        end else begin
          cyc(mk(0, !dir, dir, 1, 0, 0));
          quiet();
        end
      end
    end
  endtask

  // No ack at all: after tmo enabled cycles the transfer must drop into ERR.
  task automatic run_timeout(input logic dir, input logic [15:0] tmo);
    bus.dir_i       = dir;
    bus.wide_i      = 1'b0;
    bus.multi_i     = 1'b0;
    bus.block_size  = 12'd16;
    bus.block_count = 16'd1;
    bus.timeout_val = tmo;
    bus.start       = 1'b1;
    m_dir  = dir;
    m_mode = 1'b0;
    m_bd   = 16'd0;
    m_terr = 1'b0;
    cyc(mk(0, !dir, 0, 1, 0, 0));
    quiet();
    for (int i = 0; i < int'(tmo); i++) begin
      cyc(mk(1, 0, 0, 1, 0, 0));
      noise(dir);
    end
    m_terr = 1'b1;
    cyc(mk(0, 0, 0, 1, 0, 0));
    quiet();
    cyc(mk(0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        dir;
    logic        wide;
    logic        multi;
    logic        open;
    logic [11:0] bsize;
    logic [15:0] bcnt;
    logic [15:0] tmo;
    int          rb;
    int          total;
    int          ab;

    chk_cnt  = 0;
    pass_cnt = 0;
    clear_counts();
    m_dir  = 1'b0;
    m_mode = 1'b0;
    m_bd   = 16'd0;
    m_terr = 1'b0;
    reset           = 1'b0;
    bus.abort       = 1'b0;
    bus.dir_i       = 1'b0;
    bus.wide_i      = 1'b0;
    bus.multi_i     = 1'b0;
    bus.block_size  = '0;
    bus.block_count = '0;
    bus.timeout_val = '0;
    bus.card_busy_n = 1'b1;
    quiet();

    // Reset: every output low.
    cyc(mk(0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0));
    lit("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    cyc(mk(0, 0, 0, 0, 0, 0));

    // Single-block 4-bit read of 16 bytes.
    clear_counts();
    run_cmd(1'b1, 1'b1, 1'b0, 12'd16, 16'd0, 16'd0, 1, 0, 0);
    lit("rd_buf_we_pulses", 32'(cnt_we), 32'd4);
    lit("rd_blocks_done", 32'(bus.blocks_done), 32'd1);
    lit("rd_finished_pulses", 32'(cnt_fin), 32'd1);

    // Three-block write of 8 bytes each, card busy 5 cycles per block.
    clear_counts();
    run_cmd(1'b0, 1'b0, 1'b1, 12'd8, 16'd3, 16'd0, 1, 0, 5);
    lit("wr_buf_re_pulses", 32'(cnt_re), 32'd6);
    lit("wr_blocks_done", 32'(bus.blocks_done), 32'd3);
    lit("wr_finished_pulses", 32'(cnt_fin), 32'd1);

    // Timeout with no acks; the error stays until cleared.
    run_timeout(1'b1, 16'd10);
    lit("to_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Start together with abort in IDLE: abort wins and clears timeout_err.
    bus.block_size = 12'd16;
    bus.start      = 1'b1;
    bus.abort      = 1'b1;
    m_terr         = 1'b0;
    cyc(mk(0, 0, 0, 0, 0, 0));
    bus.abort = 1'b0;
    quiet();
    cyc(mk(0, 0, 0, 0, 0, 0));
    lit("abort_clears_terr", 32'(bus.timeout_err), 32'd0);

    // Timeout again, then a normal start must clear it (checked per cycle).
    run_timeout(1'b0, 16'd3);

    // Abort on the 2nd ack of a read: that ack must not push the buffer.
    clear_counts();
    run_cmd(1'b1, 1'b0, 1'b0, 12'd16, 16'd0, 16'd0, 1, 2, 0);
    lit("abort_buf_we_pulses", 32'(cnt_we), 32'd1);
    lit("abort_blocks_done", 32'(bus.blocks_done), 32'd0);

    // Block size below one word is rejected.
    run_cmd(1'b1, 1'b0, 1'b0, 12'd3, 16'd0, 16'd0, 1, 0, 0);
    lit("bad_size_not_busy", 32'(bus.xfer_busy), 32'd0);

    // Open-ended single-word blocks, stopped by abort on the 6th ack.
    clear_counts();
    run_cmd(1'b1, 1'b1, 1'b1, 12'd4, 16'd0, 16'd0, 6, 6, 0);
    lit("open_buf_we_pulses", 32'(cnt_we), 32'd5);
    lit("open_finished_pulses", 32'(cnt_fin), 32'd0);

    // Randomized commands.
    for (int n = 0; n < 24; n++) begin
      dir   = 1'($urandom_range(0, 1));
      wide  = 1'($urandom_range(0, 1));
      multi = 1'($urandom_range(0, 1));
      bsize = 12'($urandom_range(1, 6) * 4 + $urandom_range(0, 3));
      bcnt  = 16'($urandom_range(0, 3));
      tmo   = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(8, 40));
      open  = multi && (bcnt == 16'd0);
      rb    = $urandom_range(1, 3);
      total = (open ? rb : (multi ? int'(bcnt) : 1)) * int'(bsize[11:2]);
      if (open) ab = total;
      else      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total) : 0;
      run_cmd(dir, wide, multi, bsize, bcnt, tmo, rb, ab, -1);
      for (int k = 0; k < $urandom_range(0, 2); k++) cyc(mk(0, 0, 0, 0, 0, 0));
    end

    // Let the compare process drain the last expectation.
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
